move_controller: RTL
====================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter MAX_MOVES, default 25, move budget per game (range 1..63).
REQ-002 SHALL have port CLOCK  in  1  system clock; all state updates on posedge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports BTN_NEXT / BTN_SELECT / BTN_NEW  in  1 each  single-cycle debounced pulses: advance colour cursor, commit move, request new game.
REQ-005 SHALL have ports SIZE  in  5  board edge (2..26), and COLOR_NUM  in  4  colours in play.
REQ-006 SHALL have ports START_NEW_GAME  out  1  and STARTED_GAME  in  1  (new-game handshake to game logic).
REQ-007 SHALL have ports COLOR_SELECTED  out  3,  COLOR_SEL_SIG  out  1,  and CHANGING_COLOR  in  1  (move handshake).
REQ-008 SHALL have ports RD_ROW  out  5,  RD_COL  out  5,  RD_DATA  in  3  (board read port; RD_DATA valid in the same cycle).
REQ-009 SHALL have ports CURSOR  out  3,  MOVE_COUNT  out  6,  GAME_WON  out  1,  GAME_LOST  out  1,  and BUSY  out  1  (high in every state except IDLE and OVER).

Function
REQ-010 SHALL implement FSM states IDLE, NEW_REQ, NEW_RELEASE, CHECK, SEL_REQ, SEL_WAIT, SCAN, OVER.
REQ-011 SHALL, in IDLE or OVER on BTN_NEW, enter NEW_REQ and assert START_NEW_GAME until STARTED_GAME=1, then deassert it (NEW_RELEASE); when STARTED_GAME=0, it SHALL clear MOVE_COUNT, GAME_WON, GAME_LOST, and CURSOR and go to IDLE.
REQ-012 SHALL advance CURSOR on BTN_NEXT in any state: +1, wrap COLOR_NUM-1 -> 0; CURSOR SHALL hold 0 when COLOR_NUM <= 1.
REQ-013 SHALL, in IDLE on BTN_SELECT, latch CURSOR into COLOR_SELECTED and go to CHECK; CHECK drives RD_ROW=0, RD_COL=0 for one cycle.
REQ-014 SHALL, in CHECK, return to IDLE with no request and no count if RD_DATA equals COLOR_SELECTED (rejected move); otherwise it SHALL go to SEL_REQ.
REQ-015 SHALL, in SEL_REQ, hold COLOR_SEL_SIG=1 until CHANGING_COLOR=1, then drop it the next cycle, increment MOVE_COUNT, and go to SEL_WAIT.
REQ-016 SHALL, in SEL_WAIT, go to SCAN on CHANGING_COLOR=0.
REQ-017 SHALL, in SCAN, read cells row-major from (0,0), one per cycle, comparing RD_DATA to COLOR_SELECTED; SCAN SHALL take at most SIZE*SIZE cycles.
REQ-018 SHALL exit SCAN on the first mismatch: to IDLE, or to OVER with GAME_LOST=1 if the move limit is reached (REQ-025).
REQ-019 SHALL, if all cells match, set GAME_WON=1 and go to OVER; a win takes precedence over a loss on the same move.
REQ-020 SHALL, in OVER, ignore BTN_SELECT and accept only BTN_NEW.
REQ-021 SHALL, on BTN_NEW and BTN_SELECT in the same cycle, give BTN_NEW priority; with BTN_NEXT in the same cycle, the select SHALL latch the pre-increment CURSOR.
REQ-022 SHALL, on BTN_NEW while BUSY, set a pending flag that is honoured on the next entry to IDLE or OVER; the move in flight SHALL complete.
REQ-023 SHALL drive RD_ROW=RD_COL=0 outside CHECK and SCAN.

Reset
REQ-024 SHALL, on RESET=1, asynchronously force state IDLE and all outputs, CURSOR, MOVE_COUNT, and the pending flag to 0; in-flight handshakes SHALL be abandoned.

Configuration
REQ-025 SHALL support macro MOVE_LIMIT_EN: when defined, a mismatch scan with MOVE_COUNT >= MAX_MOVES sets GAME_LOST; when undefined, GAME_LOST is tied 0 and MOVE_COUNT saturates at 63.

Structure
REQ-026 SHALL place the FSM state enum, COLOR_W=3, COORD_W=5, and MAX_SIZE=26 in shared package flood_pkg.
REQ-027 SHALL implement the row/column scan counter as sub-module board_scanner (start, SIZE in; row, col, last out).

Verification
REQ-028 SHALL verify: BTN_NEW with a responder echoing STARTED_GAME after 3 cycles -> START_NEW_GAME high exactly until echo, then MOVE_COUNT=0 and IDLE.
REQ-029 SHALL verify: COLOR_NUM=4, 5 BTN_NEXT pulses -> CURSOR = 0,1,2,3,0,1.
REQ-030 SHALL verify: BTN_SELECT with (0,0) already equal to CURSOR -> no COLOR_SEL_SIG, MOVE_COUNT unchanged.
REQ-031 SHALL verify: SIZE=2 board flooded to colour 3 after a move -> scan of 4 cycles, GAME_WON=1, MOVE_COUNT=1.
REQ-032 SHALL verify: MOVE_LIMIT_EN, MAX_MOVES=2, two non-winning moves -> GAME_LOST=1 and BTN_SELECT ignored.
REQ-033 SHALL verify: RESET asserted mid-SCAN on a 26x26 board -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/flood_pkg.sv
// Shared widths, state encoding and cursor helper for the flood-it move controller.
package flood_pkg;

    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 5;
    localparam int MAX_SIZE = 26;
    localparam int COUNT_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        NEW_REQ,
        NEW_RELEASE,
        CHECK,
        SEL_REQ,
        SEL_WAIT,
        SCAN,
        OVER
    } state_t;

    // Cursor step with wrap at the last colour in play; a single-colour game pins it at 0.
    function automatic logic [COLOR_W-1:0] next_cursor(input logic [COLOR_W-1:0] cur,
                                                       input logic [3:0]         color_num);
        logic [3:0] wide;
        wide = {1'b0, cur} + 4'd1;
        if (color_num <= 4'd1 || wide >= color_num) begin
            return '0;
        end
        return wide[COLOR_W-1:0];
    endfunction

endpackage

// File: rtl/board_scanner.sv
// Row-major board coordinate walker: START restarts at (0,0), then one cell per clock.
module board_scanner
    import flood_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic [COORD_W-1:0] SIZE,
    output logic [COORD_W-1:0] ROW,
    output logic [COORD_W-1:0] COL,
    output logic               LAST
);

    logic [COORD_W-1:0] edge_max;

    assign edge_max = SIZE - COORD_W'(1);
    assign LAST     = (ROW == edge_max) && (COL == edge_max);

    // Free-running walk; the controller only looks at it while scanning.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ROW <= '0;
            COL <= '0;
        end else if (START) begin
            ROW <= '0;
            COL <= '0;
        end else if (COL >= edge_max) begin
            COL <= '0;
            ROW <= (ROW >= edge_max) ? '0 : ROW + COORD_W'(1);
        end else begin
            COL <= COL + COORD_W'(1);
        end
    end

endmodule

// File: rtl/move_controller.sv
// Flood-it move controller: new-game and move handshakes, colour cursor, win scan.
// Define MOVE_LIMIT_EN to lose the game once MAX_MOVES moves fail to flood the board.
module move_controller
    import flood_pkg::*;
#(
    parameter int MAX_MOVES = 25
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               BTN_NEXT,
    input  logic               BTN_SELECT,
    input  logic               BTN_NEW,
    input  logic [4:0]         SIZE,
    input  logic [3:0]         COLOR_NUM,
    output logic               START_NEW_GAME,
    input  logic               STARTED_GAME,
    output logic [COLOR_W-1:0] COLOR_SELECTED,
    output logic               COLOR_SEL_SIG,
    input  logic               CHANGING_COLOR,
    output logic [COORD_W-1:0] RD_ROW,
    output logic [COORD_W-1:0] RD_COL,
    input  logic [COLOR_W-1:0] RD_DATA,
    output logic [COLOR_W-1:0] CURSOR,
    output logic [COUNT_W-1:0] MOVE_COUNT,
    output logic               GAME_WON,
    output logic               GAME_LOST,
    output logic               BUSY
);

    if (MAX_MOVES < 1 || MAX_MOVES > 63) begin : g_bad_max_moves
        $error("MAX_MOVES must be within 1..63");
    end

    state_t             state, state_next;
    logic               latch_sel, count_inc, set_won, set_lost;
    logic               clear_game, scan_start, take_new;
    logic               new_pending, limit_hit;
    logic [COORD_W-1:0] scan_row, scan_col;
    logic               scan_last;

    board_scanner u_scanner (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .START (scan_start),
        .SIZE  (SIZE),
        .ROW   (scan_row),
        .COL   (scan_col),
        .LAST  (scan_last)
    );

`ifdef MOVE_LIMIT_EN
    logic game_lost;

    assign limit_hit = (MOVE_COUNT >= COUNT_W'(MAX_MOVES));
    assign GAME_LOST = game_lost;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            game_lost <= 1'b0;
        end else if (clear_game) begin
            game_lost <= 1'b0;
        end else if (set_lost) begin
            game_lost <= 1'b1;
        end
    end
`else
    assign limit_hit = 1'b0;
    assign GAME_LOST = 1'b0;
`endif

    assign BUSY           = (state != IDLE) && (state != OVER);
    assign START_NEW_GAME = (state == NEW_REQ);
    assign COLOR_SEL_SIG  = (state == SEL_REQ);
    assign RD_ROW         = (state == SCAN) ? scan_row : '0;
    assign RD_COL         = (state == SCAN) ? scan_col : '0;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request for a new game always beats a select arriving in the same cycle.
    always_comb begin
        state_next = state;
        latch_sel  = 1'b0;
        count_inc  = 1'b0;
        set_won    = 1'b0;
        set_lost   = 1'b0;
        clear_game = 1'b0;
        scan_start = 1'b0;
        take_new   = 1'b0;
        case (state)
            IDLE: begin
                if (BTN_NEW || new_pending) begin
                    take_new   = 1'b1;
                    state_next = NEW_REQ;
                end else if (BTN_SELECT) begin
                    latch_sel  = 1'b1;
                    state_next = CHECK;
                end
            end
            NEW_REQ: begin
                if (STARTED_GAME) state_next = NEW_RELEASE;
            end
            NEW_RELEASE: begin
                if (!STARTED_GAME) begin
                    clear_game = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                state_next = (RD_DATA == COLOR_SELECTED) ? IDLE : SEL_REQ;
            end
            SEL_REQ: begin
                if (CHANGING_COLOR) begin
                    count_inc  = 1'b1;
                    state_next = SEL_WAIT;
                end
            end
            SEL_WAIT: begin
                if (!CHANGING_COLOR) begin
                    scan_start = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (RD_DATA != COLOR_SELECTED) begin
                    set_lost   = limit_hit;
                    state_next = limit_hit ? OVER : IDLE;
                end else if (scan_last) begin
                    set_won    = 1'b1;
                    state_next = OVER;
                end
            end
            OVER: begin
                if (BTN_NEW || new_pending) begin
                    take_new   = 1'b1;
                    state_next = NEW_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new-game press during a move is remembered until the controller is idle again.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            new_pending <= 1'b0;
        end else if (take_new) begin
            new_pending <= 1'b0;
        end else if (BTN_NEW && BUSY) begin
            new_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            CURSOR         <= '0;
            COLOR_SELECTED <= '0;
            MOVE_COUNT     <= '0;
            GAME_WON       <= 1'b0;
        end else begin
            if (latch_sel) COLOR_SELECTED <= CURSOR;
            if (clear_game || COLOR_NUM <= 4'd1) begin
                CURSOR <= '0;
            end else if (BTN_NEXT) begin
                CURSOR <= next_cursor(CURSOR, COLOR_NUM);
            end
            if (clear_game) begin
                MOVE_COUNT <= '0;
            end else if (count_inc && MOVE_COUNT != '1) begin
                MOVE_COUNT <= MOVE_COUNT + COUNT_W'(1);
            end
            if (clear_game) begin
                GAME_WON <= 1'b0;
            end else if (set_won) begin
                GAME_WON <= 1'b1;
            end
        end
    end

endmodule
